display_7_seg_mux: RTL and testbench



---
 rtl/display_7_seg_mux.sv | 143 ++++++++++++++
 tb/tb_display_7_seg_mux.sv | 137 +++++++++++++
 2 files changed

// File: rtl/display_7_seg_mux.sv
// Time-multiplexed driver for common-anode 7-segment arrays with PWM brightness,
// leading-zero suppression, an anti-ghosting guard cycle and frame-coherent input capture.
module display_7_seg_mux #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SUB_TICKS  = 6250
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [7:0]              SEG,
  output logic [NUM_DIGITS-1:0]   DIGIT,
  output logic                    frame_tick
);

  localparam int unsigned SubW = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
  localparam int unsigned PosW = $clog2(NUM_DIGITS);
  localparam logic [SubW-1:0] SubLast = SubW'(SUB_TICKS - 1);
  localparam logic [PosW-1:0] PosLast = PosW'(NUM_DIGITS - 1);

  logic [SubW-1:0] sub_cnt_q, sub_cnt_d;
  logic [3:0]      phase_q, phase_d;
  logic [PosW-1:0] pos_q, pos_d;

  logic [4*NUM_DIGITS-1:0] digits_snap_q, digits_snap_d;
  logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic [NUM_DIGITS-1:0]   blank_snap_q, blank_snap_d;
  logic                    lz_snap_q, lz_snap_d;
  logic [3:0]              bright_snap_q, bright_snap_d;

  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  sub_wrap, phase_wrap, slot_start, frame_start;
  logic [NUM_DIGITS-1:0] supp;
  logic [3:0]            cur_val;
  logic                  cur_dark;
  logic [6:0]            dec;

  always_comb begin
    sub_wrap    = (sub_cnt_q == SubLast);
    phase_wrap  = (phase_q == 4'd15);
    slot_start  = (sub_cnt_q == '0) && (phase_q == 4'd0);
    frame_start = slot_start && (pos_q == '0);

    sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
    phase_d   = sub_wrap ? phase_q + 4'd1 : phase_q;
    pos_d     = pos_q;
    if (sub_wrap && phase_wrap) begin
      pos_d = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
    end
  end

  // The _d snapshot equals the live inputs on the frame-start cycle, so the first
  // output cycle of a frame already reflects the freshly captured values.
  always_comb begin
    digits_snap_d = frame_start ? digits      : digits_snap_q;
    dp_snap_d     = frame_start ? dp          : dp_snap_q;
    blank_snap_d  = frame_start ? blank       : blank_snap_q;
    lz_snap_d     = frame_start ? lz_suppress : lz_snap_q;
    bright_snap_d = frame_start ? brightness  : bright_snap_q;
  end

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    supp       = '0;
    for (int p = NUM_DIGITS - 1; p >= 0; p--) begin
      zero_above = zero_above && (digits_snap_d[4*p +: 4] == 4'd0);
      supp[p]    = lz_snap_d && zero_above && (p != 0);
    end
  end

  always_comb begin
    cur_val  = digits_snap_d[{pos_q, 2'b00} +: 4];
    cur_dark = blank_snap_d[pos_q] | supp[pos_q];
    unique case (cur_val)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  end

  always_comb begin
    seg_d = cur_dark ? 8'hFF : {~dp_snap_d[pos_q], dec};
    if (slot_start || cur_dark || (phase_q > bright_snap_d)) begin
      digit_d = '1;
    end else begin
      digit_d = ~(NUM_DIGITS'(1) << pos_q);
    end
    frame_tick_d = frame_start;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sub_cnt_q     <= '0;
      phase_q       <= '0;
      pos_q         <= '0;
      digits_snap_q <= '0;
      dp_snap_q     <= '0;
      blank_snap_q  <= '0;
      lz_snap_q     <= 1'b0;
      bright_snap_q <= '0;
      seg_q         <= 8'hFF;
      digit_q       <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      sub_cnt_q     <= sub_cnt_d;
      phase_q       <= phase_d;
      pos_q         <= pos_d;
      digits_snap_q <= digits_snap_d;
      dp_snap_q     <= dp_snap_d;
      blank_snap_q  <= blank_snap_d;
      lz_snap_q     <= lz_snap_d;
      bright_snap_q <= bright_snap_d;
      seg_q         <= seg_d;
      digit_q       <= digit_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign SEG        = seg_q;
  assign DIGIT      = digit_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_7_seg_mux.sv
// Bench for display_7_seg_mux: directed scenarios then random traffic, every cycle
// checked against a position/phase arithmetic model of the display.
module tb_display_7_seg_mux;

  localparam int N     = 4;
  localparam int S     = 2;
  localparam int SLOT  = 16 * S;
  localparam int FRAME = SLOT * N;

  logic          clk;
  logic          rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]  dp;
  logic [N-1:0]  blank;
  logic          lz;
  logic [3:0]    bright;
  logic [7:0]    seg;
  logic [N-1:0]  dig;
  logic          tick_o;

  int compared = 0;
  int mismatched = 0;

  display_7_seg_mux #(.NUM_DIGITS(N), .SUB_TICKS(S)) dut (
    .CLK(clk), .RST(rst), .digits(digits), .dp(dp), .blank(blank),
    .lz_suppress(lz), .brightness(bright), .SEG(seg), .DIGIT(dig), .frame_tick(tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: n = clock edges since reset released; snapshot of inputs per frame.
  int             n = 0;
  logic [4*N-1:0] s_digits;
  logic [N-1:0]   s_dp, s_blank;
  logic           s_lz;
  logic [3:0]     s_bright;
  logic [7:0]     e_seg;
  logic [N-1:0]   e_dig;
  logic           e_tick;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic model();
    int m, pos, off, ph, v;
    logic dark, supp;
    if (rst) begin
      e_seg = 8'hFF; e_dig = '1; e_tick = 1'b0; n = 0;
    end else begin
      m = n % FRAME;
      if (m == 0) begin
        s_digits = digits; s_dp = dp; s_blank = blank; s_lz = lz; s_bright = bright;
      end
      pos  = m / SLOT;
      off  = m % SLOT;
      ph   = off / S;
      v    = int'((s_digits >> (4 * pos)) & 16'hF);
      // Suppressed when this digit and everything above it read as zero.
      supp = s_lz && (pos != 0) && ((s_digits >> (4 * pos)) == 0);
      dark = s_blank[pos] || supp;
      e_seg  = dark ? 8'hFF : {~s_dp[pos], lut[v][6:0]};
      e_dig  = (off == 0 || dark || ph > int'(s_bright)) ? '1 : ~(N'(1) << pos);
      e_tick = (m == 0);
      n++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    cmp("SEG", 32'(seg), 32'(e_seg));
    cmp("DIGIT", 32'(dig), 32'(e_dig));
    cmp("frame_tick", 32'(tick_o), 32'(e_tick));
    cmp("onehot_low", 32'($countones(~dig) <= 1), 32'd1);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Advance until the next edge is a frame start (bounded by one frame).
  task automatic align();
    for (int i = 0; i < FRAME && (n % FRAME) != 0; i++) step();
  endtask

  initial begin
    rst = 1'b1; digits = 16'h3210; dp = '0; blank = '0; lz = 1'b0; bright = 4'd15;
    run(3);
    rst = 1'b0;
    run(FRAME + 4);

    lz = 1'b1; digits = 16'h0050;
    align(); run(FRAME);
    digits = 16'h0000;
    align(); run(FRAME);

    lz = 1'b0; digits = 16'h3210; bright = 4'd3; dp = 4'b0001;
    align(); run(FRAME);

    bright = 4'd15; dp = '0; digits = 16'h1111;
    align(); run(SLOT + SLOT / 2);
    digits = 16'h2222;
    run(2 * FRAME);

    align(); run(2 * SLOT + 5);
    rst = 1'b1; run(2);
    rst = 1'b0; digits = 16'hABCD; blank = 4'b0100;
    run(FRAME + 8);

    repeat (30) begin
      digits = 16'($urandom);
      if ($urandom_range(0, 2) == 0) digits[15:8] = 8'h00;
      dp     = 4'($urandom);
      blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      lz     = 1'($urandom);
      bright = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; run($urandom_range(1, 3)); rst = 1'b0;
      end
      run($urandom_range(1, 300));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
